calc_display: RTL

//  Receiving end of the calculator's serial digit stream (status/data/pos). Captures digits 0..7

---
 rtl/calc_pkg.sv | 27 ++
 rtl/seg7_decoder.sv | 28 ++
 rtl/calc_display.sv | 123 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display receiver:
// producer status codes, digit type and fixed active-low segment glyphs.
package calc_pkg;

    localparam int N_DIG = 8;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        ST_ERRO    = 2'b00,
        ST_OCUPADO = 2'b01,
        ST_PRONTO  = 2'b10
    } status_t;

    // Segment order {g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h23;

    // Non-BCD input is stored as 4'hF so it renders as a dash
    function automatic digit_t sanitize(input digit_t d);
        return (d > 4'd9) ? 4'hF : d;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-7-segment decoder, active-low {g,f,e,d,c,b,a}.
// 4'hF renders a dash; 10..14 are blank.
module seg7_decoder
    import calc_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            4'hF:    seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// Receives the calculator's serial digit stream into a shadow buffer, commits
// whole frames on end-of-frame, and scans the committed frame onto 8 displays.
module calc_display
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       frame_tick,
    output logic       err
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    digit_t           shadow_reg [N_DIG];
    digit_t           active_reg [N_DIG];
    logic             prev_lt8_reg;
    logic [DIV_W-1:0] div_reg;
    logic [2:0]       scan_idx_reg;
    logic [7:0]       an_reg;
    logic [6:0]       seg_reg;
    logic [6:0]       seg_next;
    logic             frame_tick_reg;
    logic             err_reg;

    logic             pos_lt8;
    logic             capture;
    logic             commit;
    logic [N_DIG-1:0] nonzero;
    logic [N_DIG-1:0] lz_blank;
    logic [6:0]       dec_seg;

    assign pos_lt8 = ~pos[3];
    assign capture = pos_lt8 && (status != ST_PRONTO);
    // Only the first end-of-frame beat after a data beat commits
    assign commit  = !pos_lt8 && prev_lt8_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIG; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
            prev_lt8_reg   <= 1'b0;
            frame_tick_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            if (capture)
                shadow_reg[pos[2:0]] <= sanitize(data);
            if (commit) begin
                for (int i = 0; i < N_DIG; i++)
                    active_reg[i] <= shadow_reg[i];
            end
            prev_lt8_reg   <= pos_lt8;
            frame_tick_reg <= commit;
            err_reg        <= err_reg | (status == ST_ERRO);
        end
    end

    // Digit i (i > 0) is a leading zero when it and everything above it is zero
    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_lz
            assign nonzero[gi] = |active_reg[gi];
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = BLANK_LZ && (nonzero[N_DIG-1:gi] == '0);
            end
        end
    endgenerate

    seg7_decoder u_dec (
        .digit (active_reg[scan_idx_reg]),
        .seg   (dec_seg)
    );

    always_comb begin
        seg_next = dec_seg;
        if (err_reg) begin
            case (scan_idx_reg)
                3'd0:    seg_next = SEG_O;
                3'd1:    seg_next = SEG_R;
                3'd2:    seg_next = SEG_R;
                3'd3:    seg_next = SEG_E;
                default: seg_next = SEG_BLANK;
            endcase
        end else if (lz_blank[scan_idx_reg]) begin
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_reg      <= '0;
            scan_idx_reg <= '0;
            an_reg       <= 8'hFF;
            seg_reg      <= SEG_BLANK;
        end else begin
            if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
                div_reg      <= '0;
                scan_idx_reg <= scan_idx_reg + 3'd1;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
            an_reg  <= ~(8'b1 << scan_idx_reg);
            seg_reg <= seg_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign frame_tick = frame_tick_reg;
    assign err        = err_reg;

endmodule
